// File: rtl/controle_medida_eco_if.sv
// Signal bundle between the top-level control FSM / sensor pins and the echo measurement controller.
interface controle_medida_eco_if #(
   parameter int W = 16
);
   logic         iniciar;
   logic         modo_continuo;
   logic         echo;
   logic         trigger;
   logic [W-1:0] medida;
   logic         pronto;
   logic         timeout;
   logic         ocupado;
   logic [3:0]   db_estado;

   modport master (
      output iniciar, modo_continuo, echo,
      input  trigger, medida, pronto, timeout, ocupado, db_estado
   );

   modport slave (
      input  iniciar, modo_continuo, echo,
      output trigger, medida, pronto, timeout, ocupado, db_estado
   );
endinterface

// File: rtl/controle_medida_eco.sv
// Sequences one ultrasonic distance measurement: trigger pulse, echo wait, echo width in microseconds.
// Owns the microsecond prescaler and the saturating microsecond counter timing every state.
module controle_medida_eco #(
   parameter int CLK_US     = 50,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int PERIODO_US = 60000,
   parameter int W          = 16
) (
   input  logic                  clock,
   input  logic                  zera_as_n,
   controle_medida_eco_if.slave  io
);

   localparam int PW = (CLK_US > 1) ? $clog2(CLK_US) : 1;
   localparam logic [PW-1:0] PRESC_FIM   = PW'(CLK_US - 1);
   localparam logic [W-1:0]  TRIG_FIM    = W'(TRIG_US - 1);
   localparam logic [W-1:0]  TIMEOUT_FIM = W'(TIMEOUT_US - 1);
   localparam logic [W-1:0]  PERIODO_FIM = W'(PERIODO_US - 1);

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARA        = 4'd1,
      TRIGGER        = 4'd2,
      ESPERA_ECO     = 4'd3,
      MEDE           = 4'd4,
      ARMAZENA       = 4'd5,
      ERRO           = 4'd6,
      FINAL          = 4'd7,
      ESPERA_PERIODO = 4'd8
   } estado_t;

   estado_t       estado;
   estado_t       prox;
   logic          echo_s1;
   logic          echo_s;
   logic [PW-1:0] presc;
   logic [W-1:0]  us_cnt;
   logic [W-1:0]  us_prox;
   logic [W-1:0]  captura;
   logic [W-1:0]  medida_r;
   logic          trigger_r;
   logic          pronto_r;
   logic          timeout_r;
   logic          tick_us;
   logic          fim_trig;
   logic          fim_timeout;
   logic          fim_periodo;

   // The "fim_*" flags fire in the cycle whose tick makes the count reach the target,
   // so a state lasts exactly target*CLK_US cycles from its entry.
   assign tick_us     = (presc == PRESC_FIM);
   assign us_prox     = (tick_us && (us_cnt != '1)) ? us_cnt + W'(1) : us_cnt;
   assign fim_trig    = tick_us && (us_cnt == TRIG_FIM);
   assign fim_timeout = tick_us && (us_cnt == TIMEOUT_FIM);
   assign fim_periodo = tick_us && (us_cnt == PERIODO_FIM);

   // State register, echo synchronizer, timing datapath and registered outputs.
   // captura tracks the count as it stands leaving MEDE, so ARMAZENA can publish it
   // even though the counter is cleared on entry to ARMAZENA.
   always_ff @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         estado    <= INICIAL;
         echo_s1   <= 1'b0;
         echo_s    <= 1'b0;
         presc     <= '0;
         us_cnt    <= '0;
         captura   <= '0;
         medida_r  <= '0;
         trigger_r <= 1'b0;
         pronto_r  <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         estado  <= prox;
         echo_s1 <= io.echo;
         echo_s  <= echo_s1;
         if (prox != estado) begin
            presc  <= '0;
            us_cnt <= '0;
         end else begin
            presc  <= tick_us ? '0 : presc + PW'(1);
            us_cnt <= us_prox;
         end
         if (estado == MEDE)
            captura <= us_prox;
         if (estado == ARMAZENA)
            medida_r <= captura;
         if (estado == PREPARA)
            timeout_r <= 1'b0;
         else if (estado == ERRO)
            timeout_r <= 1'b1;
         trigger_r <= (prox == TRIGGER);
         pronto_r  <= (prox == FINAL);
      end
   end

   // Next-state logic; an echo edge takes priority over a timeout reached in the same cycle.
   always_comb begin
      prox = estado;
      case (estado)
         INICIAL:        if (io.iniciar) prox = PREPARA;
         PREPARA:        prox = TRIGGER;
         TRIGGER:        if (fim_trig) prox = ESPERA_ECO;
         ESPERA_ECO: begin
            if (echo_s)           prox = MEDE;
            else if (fim_timeout) prox = ERRO;
         end
         MEDE: begin
            if (!echo_s)          prox = ARMAZENA;
            else if (fim_timeout) prox = ERRO;
         end
         ARMAZENA:       prox = FINAL;
         ERRO:           prox = FINAL;
         FINAL:          prox = io.modo_continuo ? ESPERA_PERIODO : INICIAL;
         ESPERA_PERIODO: begin
            if (!io.modo_continuo) prox = INICIAL;
            else if (fim_periodo)  prox = PREPARA;
         end
         default:        prox = INICIAL;
      endcase
   end

   assign io.trigger   = trigger_r;
   assign io.medida    = medida_r;
   assign io.pronto    = pronto_r;
   assign io.timeout   = timeout_r;
   assign io.ocupado   = (estado != INICIAL);
   assign io.db_estado = estado;

endmodule

// File: tb/tb_controle_medida_eco.sv
// Self-checking bench for controle_medida_eco using small timing parameters (2 cycles/us, 8-bit count).
module tb_controle_medida_eco;

   localparam int W = 8;

   typedef struct {
      logic         iniciar;
      logic         echo;
      logic         trig;
      logic         pronto;
      logic         tout;
      logic         ocup;
      logic [3:0]   db;
      logic [W-1:0] med;
   } vec_t;

   logic clock = 1'b0;
   logic zera_as_n = 1'b0;
   int   n_checks = 0;
   int   n_fails = 0;
   int   cyc = 0;
   int   prep_cnt = 0;
   vec_t vecs[$];

   controle_medida_eco_if #(.W(W)) io ();

   controle_medida_eco #(
      .CLK_US(2), .TRIG_US(3), .TIMEOUT_US(20), .PERIODO_US(10), .W(W)
   ) dut (
      .clock(clock),
      .zera_as_n(zera_as_n),
      .io(io)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic step();
      @(negedge clock);
      cyc++;
      if (io.db_estado == 4'd1) prep_cnt++;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      io.iniciar = v.iniciar;
      io.echo    = v.echo;
      step();
      checkOutput($sformatf("vec%0d_trigger", idx), io.trigger, v.trig);
      checkOutput($sformatf("vec%0d_pronto", idx), io.pronto, v.pronto);
      checkOutput($sformatf("vec%0d_timeout", idx), io.timeout, v.tout);
      checkOutput($sformatf("vec%0d_ocupado", idx), io.ocupado, v.ocup);
      checkOutput($sformatf("vec%0d_db_estado", idx), io.db_estado, v.db);
      checkOutput($sformatf("vec%0d_medida", idx), io.medida, v.med);
   endtask

   task automatic add(input logic ini, input logic e, input logic tr, input logic pr,
                      input logic to, input logic oc, input logic [3:0] db, input logic [W-1:0] med);
      vecs.push_back('{ini, e, tr, pr, to, oc, db, med});
   endtask

   task automatic wait_db(input logic [3:0] code, input int bound, input string name);
      int n = 0;
      while (io.db_estado != code && n < bound) begin
         step();
         n++;
      end
      checkOutput(name, io.db_estado, code);
   endtask

   task automatic wait_trig(input int bound, input string name);
      int n = 0;
      while (io.trigger !== 1'b1 && n < bound) begin
         step();
         n++;
      end
      checkOutput(name, io.trigger, 1);
   endtask

   task automatic start_meas();
      io.iniciar = 1'b1;
      step();
      io.iniciar = 1'b0;
   endtask

   initial begin
      int n;
      int t[3];
      io.iniciar       = 1'b0;
      io.modo_continuo = 1'b0;
      io.echo          = 1'b0;

      // Reset values
      repeat (2) step();
      checkOutput("reset_trigger", io.trigger, 0);
      checkOutput("reset_medida", io.medida, 0);
      checkOutput("reset_pronto", io.pronto, 0);
      checkOutput("reset_timeout", io.timeout, 0);
      checkOutput("reset_ocupado", io.ocupado, 0);
      checkOutput("reset_db_estado", io.db_estado, 0);
      zera_as_n = 1'b1;

      // Single good measurement: 14-cycle echo -> 7 us
      add(1, 0, 0, 0, 0, 1, 4'd1, 8'd0);
      for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 0, 1, 4'd2, 8'd0);
      add(0, 0, 0, 0, 0, 1, 4'd3, 8'd0);
      for (int i = 0; i < 2; i++) add(0, 1, 0, 0, 0, 1, 4'd3, 8'd0);
      for (int i = 0; i < 12; i++) add(0, 1, 0, 0, 0, 1, 4'd4, 8'd0);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 1, 4'd4, 8'd0);
      add(0, 0, 0, 0, 0, 1, 4'd5, 8'd0);
      add(0, 0, 0, 1, 0, 1, 4'd7, 8'd7);
      add(0, 0, 0, 0, 0, 0, 4'd0, 8'd7);
      add(0, 0, 0, 0, 0, 0, 4'd0, 8'd7);
      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // No echo: ESPERA_ECO lasts 40 cycles, then ERRO
      start_meas();
      wait_db(4'd3, 20, "no_echo_reach_espera");
      n = 0;
      while (io.db_estado == 4'd3 && n < 100) begin
         n++;
         step();
      end
      checkOutput("espera_eco_cycles", n, 40);
      checkOutput("erro_state", io.db_estado, 6);
      step();
      checkOutput("erro_final_pronto", io.pronto, 1);
      checkOutput("erro_final_timeout", io.timeout, 1);
      checkOutput("erro_final_medida", io.medida, 7);
      step();
      checkOutput("erro_inicial_pronto", io.pronto, 0);
      checkOutput("erro_inicial_timeout", io.timeout, 1);

      // Following good measurement clears timeout; 10-cycle echo -> 5 us
      start_meas();
      step();
      checkOutput("timeout_cleared_in_trigger", io.timeout, 0);
      wait_db(4'd3, 20, "good_reach_espera");
      io.echo = 1'b1;
      repeat (10) step();
      io.echo = 1'b0;
      wait_db(4'd7, 40, "good_reach_final");
      checkOutput("good_medida", io.medida, 5);
      checkOutput("good_timeout", io.timeout, 0);

      // Echo stuck high: ignored during PREPARA/TRIGGER, MEDE times out after 40 cycles
      step();
      io.echo = 1'b1;
      start_meas();
      step();
      n = 0;
      while (io.trigger === 1'b1 && n < 50) begin
         n++;
         step();
      end
      checkOutput("stuck_trigger_width", n, 6);
      checkOutput("stuck_espera_first", io.db_estado, 3);
      step();
      checkOutput("stuck_mede_next", io.db_estado, 4);
      n = 0;
      while (io.db_estado == 4'd4 && n < 100) begin
         n++;
         step();
      end
      checkOutput("mede_timeout_cycles", n, 40);
      checkOutput("mede_erro_state", io.db_estado, 6);
      step();
      checkOutput("stuck_final_timeout", io.timeout, 1);
      checkOutput("stuck_final_medida", io.medida, 5);
      io.echo = 1'b0;
      step();

      // Continuous mode with 8-cycle echo: period of 40 cycles between trigger rises
      io.modo_continuo = 1'b1;
      start_meas();
      for (int r = 0; r < 3; r++) begin
         wait_trig(200, "cont_trigger_rise");
         t[r] = cyc;
         wait_db(4'd3, 20, "cont_reach_espera");
         io.echo = 1'b1;
         repeat (8) step();
         io.echo = 1'b0;
         wait_db(4'd7, 40, "cont_reach_final");
         checkOutput("cont_medida", io.medida, 4);
         checkOutput("cont_pronto", io.pronto, 1);
      end
      checkOutput("cont_period_1", t[1] - t[0], 40);
      checkOutput("cont_period_2", t[2] - t[1], 40);
      wait_db(4'd8, 5, "cont_reach_periodo");
      repeat (3) step();
      io.modo_continuo = 1'b0;
      step();
      checkOutput("cont_stop_state", io.db_estado, 0);
      checkOutput("cont_stop_ocupado", io.ocupado, 0);
      n = 0;
      repeat (60) begin
         step();
         if (io.trigger === 1'b1) n++;
      end
      checkOutput("cont_stop_no_trigger", n, 0);

      // Reset during MEDE clears everything without waiting for a clock edge
      start_meas();
      wait_db(4'd3, 20, "rst_reach_espera");
      io.echo = 1'b1;
      wait_db(4'd4, 10, "rst_reach_mede");
      repeat (3) step();
      #2 zera_as_n = 1'b0;
      #1;
      checkOutput("rst_mede_db_estado", io.db_estado, 0);
      checkOutput("rst_mede_ocupado", io.ocupado, 0);
      checkOutput("rst_mede_medida", io.medida, 0);
      checkOutput("rst_mede_pronto", io.pronto, 0);
      checkOutput("rst_mede_timeout", io.timeout, 0);
      io.echo = 1'b0;
      step();
      zera_as_n = 1'b1;

      // Reset during TRIGGER drops the pin immediately
      start_meas();
      step();
      checkOutput("rst_trig_before", io.trigger, 1);
      #2 zera_as_n = 1'b0;
      #1;
      checkOutput("rst_trig_after", io.trigger, 0);
      step();
      zera_as_n = 1'b1;

      // iniciar held high: one measurement per visit to INICIAL
      step();
      prep_cnt = 0;
      io.iniciar = 1'b1;
      for (int r = 0; r < 2; r++) begin
         wait_db(4'd3, 20, "held_reach_espera");
         io.echo = 1'b1;
         repeat (8) step();
         io.echo = 1'b0;
         wait_db(4'd7, 40, "held_reach_final");
         checkOutput("held_medida", io.medida, 4);
         step();
         checkOutput("held_inicial_visit", io.db_estado, 0);
      end
      io.iniciar = 1'b0;
      repeat (2) step();
      checkOutput("held_prepara_count", prep_cnt, 2);
      checkOutput("held_idle", io.db_estado, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
